// File: rtl/sram_instruction_mem_arbiter_pkg.sv
// Shared types and widths for the instruction/weight SRAM arbiter.
// owner_t identifies which Avalon master owns a grant or a pending read.
package sram_arb_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    endfunction

endpackage

// File: rtl/sram_instruction_mem_arbiter_if.sv
// Bundle of both Avalon-MM master ports and the single SRAM port.
// slave: arbiter side; master: the agents driving the requests and the SRAM read data.
interface sram_instruction_mem_arbiter_if;
    import sram_arb_pkg::*;

    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] sram_address;
    logic [BE_W-1:0]   sram_byteenable;
    logic              sram_chipselect;
    logic              sram_write;
    logic [DATA_W-1:0] sram_writedata;
    logic              sram_clken;
    logic [DATA_W-1:0] sram_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output sram_address, sram_byteenable, sram_chipselect, sram_write,
        output sram_writedata, sram_clken,
        input  sram_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  sram_address, sram_byteenable, sram_chipselect, sram_write,
        input  sram_writedata, sram_clken,
        output sram_readdata
    );

endinterface

// File: rtl/sram_instruction_mem_arbiter_rr_arbiter2.sv
// Two-requester grant logic with last-grant memory; RR_EN=0 degrades to m0 fixed priority.
// last_grant only moves when a grant is actually issued, so freeze holds it.
module rr_arbiter2
    import sram_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_req0,
    input  logic   i_req1,
    input  logic   i_freeze,
    output logic   o_valid,
    output owner_t o_grant
);

    owner_t r_last_grant;
    owner_t w_grant;
    logic   w_valid;

    always_comb begin
        w_grant = OWNER_M0;
        w_valid = (i_req0 | i_req1) & ~i_freeze;
        if (i_req0 && i_req1) begin
            w_grant = RR_EN ? other_owner(r_last_grant) : OWNER_M0;
        end else if (i_req1) begin
            w_grant = OWNER_M1;
        end
    end

    // Reset to m1 so that m0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= OWNER_M1;
        end else if (w_valid) begin
            r_last_grant <= w_grant;
        end
    end

    assign o_valid = w_valid;
    assign o_grant = w_grant;

endmodule

// File: rtl/sram_instruction_mem_arbiter.sv
// Shares one single-port instruction/weight SRAM between two Avalon-MM masters,
// one access per cycle, and steers the 1-cycle read return back to its owner.
module sram_instruction_mem_arbiter
    import sram_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input logic                          clk,
    input logic                          reset_n,
    input logic                          freeze,
    sram_instruction_mem_arbiter_if.slave io_bus
);

    logic              w_req0;
    logic              w_req1;
    logic              w_valid;
    owner_t            w_grant;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_rd_accept;
    logic [ADDR_W-1:0] w_address;
    logic [BE_W-1:0]   w_byteenable;
    logic [DATA_W-1:0] w_writedata;
    logic              w_write;
    logic              r_rd_pend;
    owner_t            r_rd_owner;

    assign w_req0 = io_bus.m0_read | io_bus.m0_write;
    assign w_req1 = io_bus.m1_read | io_bus.m1_write;

    rr_arbiter2 #(
        .RR_EN (RR_EN)
    ) u_rr_arbiter2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req0   (w_req0),
        .i_req1   (w_req1),
        .i_freeze (freeze),
        .o_valid  (w_valid),
        .o_grant  (w_grant)
    );

    assign w_grant0 = w_valid & (w_grant == OWNER_M0);
    assign w_grant1 = w_valid & (w_grant == OWNER_M1);

    // Write wins over a simultaneous read; byte lanes are forced on for reads.
    always_comb begin
        w_address    = '0;
        w_byteenable = '0;
        w_writedata  = '0;
        w_write      = 1'b0;
        if (w_grant0) begin
            w_address    = io_bus.m0_address;
            w_write      = io_bus.m0_write;
            w_writedata  = io_bus.m0_writedata;
            w_byteenable = io_bus.m0_write ? io_bus.m0_byteenable : '1;
        end else if (w_grant1) begin
            w_address    = io_bus.m1_address;
            w_write      = io_bus.m1_write;
            w_writedata  = io_bus.m1_writedata;
            w_byteenable = io_bus.m1_write ? io_bus.m1_byteenable : '1;
        end
    end

    assign w_rd_accept = w_valid & ~w_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= OWNER_M0;
        end else begin
            r_rd_pend <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_owner <= w_grant;
            end
        end
    end

    assign io_bus.m0_waitrequest   = w_req0 & ~w_grant0;
    assign io_bus.m1_waitrequest   = w_req1 & ~w_grant1;

    assign io_bus.m0_readdatavalid = r_rd_pend & (r_rd_owner == OWNER_M0);
    assign io_bus.m1_readdatavalid = r_rd_pend & (r_rd_owner == OWNER_M1);
    assign io_bus.m0_readdata      = io_bus.m0_readdatavalid ? io_bus.sram_readdata : '0;
    assign io_bus.m1_readdata      = io_bus.m1_readdatavalid ? io_bus.sram_readdata : '0;

    assign io_bus.sram_address     = w_address;
    assign io_bus.sram_byteenable  = w_byteenable;
    assign io_bus.sram_writedata   = w_writedata;
    assign io_bus.sram_write       = w_write;
    assign io_bus.sram_chipselect  = w_valid;
    assign io_bus.sram_clken       = 1'b1;

endmodule

// File: tb/tb_sram_instruction_mem_arbiter.sv
// Bench for the SRAM arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (memory array, preferred-master flag, pending read).
module tb_sram_instruction_mem_arbiter;
    import sram_arb_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic freeze = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_instruction_mem_arbiter_if bus ();
    sram_instruction_mem_arbiter_if fbus ();

    sram_instruction_mem_arbiter #(.RR_EN(1'b1)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .freeze  (freeze),
        .io_bus  (bus)
    );

    sram_instruction_mem_arbiter #(.RR_EN(1'b0)) u_dut_fp (
        .clk     (clk),
        .reset_n (reset_n),
        .freeze  (freeze),
        .io_bus  (fbus)
    );

    // Behavioural single-port SRAM behind the round-robin instance.
    logic [31:0] sram_mem [0:8191];
    always @(posedge clk) begin
        if (bus.sram_chipselect) begin
            if (bus.sram_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_byteenable[b])
                        sram_mem[bus.sram_address][8*b +: 8] <= bus.sram_writedata[8*b +: 8];
            end else begin
                bus.sram_readdata <= sram_mem[bus.sram_address];
            end
        end
    end

    always @(posedge clk) begin
        assert (!(bus.m0_read && bus.m0_write)) else $error("FAIL rw_both m0");
        assert (!(bus.m1_read && bus.m1_write)) else $error("FAIL rw_both m1");
    end

    // Reference model: who wins next contention, memory contents, one pending read.
    logic [31:0] ref_mem [0:8191];
    int          ref_pref;
    bit          ref_pend;
    int          ref_owner;
    logic [31:0] ref_data;

    function automatic int model_grant();
        bit q0, q1;
        q0 = bus.m0_read | bus.m0_write;
        q1 = bus.m1_read | bus.m1_write;
        if (freeze || !(q0 || q1)) return -1;
        if (q0 && q1) return ref_pref;
        return q0 ? 0 : 1;
    endfunction

    function automatic logic [118:0] exp_vec();
        int g;
        logic cs, we, v0, v1;
        logic [12:0] a;
        logic [3:0] be;
        logic [31:0] wd;
        g = model_grant();
        cs = 1'b0; we = 1'b0; a = '0; be = '0; wd = '0;
        if (g == 0) begin
            cs = 1'b1; we = bus.m0_write; a = bus.m0_address; wd = bus.m0_writedata;
            be = we ? bus.m0_byteenable : 4'hF;
        end else if (g == 1) begin
            cs = 1'b1; we = bus.m1_write; a = bus.m1_address; wd = bus.m1_writedata;
            be = we ? bus.m1_byteenable : 4'hF;
        end
        v0 = ref_pend && ref_owner == 0;
        v1 = ref_pend && ref_owner == 1;
        return {(bus.m0_read | bus.m0_write) && g != 0, (bus.m1_read | bus.m1_write) && g != 1,
                cs, we, a, be, wd, v0, v1, v0 ? ref_data : 32'h0, v1 ? ref_data : 32'h0};
    endfunction

    function automatic logic [118:0] obs_vec();
        return {bus.m0_waitrequest, bus.m1_waitrequest, bus.sram_chipselect, bus.sram_write,
                bus.sram_address, bus.sram_byteenable, bus.sram_writedata,
                bus.m0_readdatavalid, bus.m1_readdatavalid, bus.m0_readdata, bus.m1_readdata};
    endfunction

    task automatic model_commit();
        int g;
        logic wr;
        logic [12:0] a;
        logic [3:0] be;
        logic [31:0] wd;
        g = model_grant();
        ref_pend = 1'b0;
        if (g >= 0) begin
            ref_pref = 1 - g;
            wr = (g == 0) ? bus.m0_write : bus.m1_write;
            a  = (g == 0) ? bus.m0_address : bus.m1_address;
            be = (g == 0) ? bus.m0_byteenable : bus.m1_byteenable;
            wd = (g == 0) ? bus.m0_writedata : bus.m1_writedata;
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
            end else begin
                ref_pend  = 1'b1;
                ref_owner = g;
                ref_data  = ref_mem[a];
            end
        end
    endtask

    // Called at the sample point; returns at the next falling edge.
    task automatic tick();
        model_commit();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_m(input int m, input bit rd, input bit wr, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (m == 0) begin
            bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
            bus.m0_byteenable = be; bus.m0_writedata = wd;
        end else begin
            bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
            bus.m1_byteenable = be; bus.m1_writedata = wd;
        end
    endtask

    task automatic idle_all();
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 0, '0, '0, '0);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.sram_chipselect !== 1'b0 || bus.m0_readdatavalid !== 1'b0 ||
            bus.m1_readdatavalid !== 1'b0 || bus.sram_clken !== 1'b1) begin
            errors++;
            $display("FAIL reset_init cs=%b v0=%b v1=%b clken=%b want 0 0 0 1",
                     bus.sram_chipselect, bus.m0_readdatavalid, bus.m1_readdatavalid,
                     bus.sram_clken);
        end
        reset_n = 1'b1;
        set_m(0, 1, 0, 13'h005, 4'h0, 32'h0);
        #4 tick();
        // Read accepted; assert reset before its return cycle.
        idle_all();
        reset_n = 1'b0;
        ref_pend = 1'b0;
        ref_pref = 0;
        #1;
        checks++;
        if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0 ||
            bus.sram_chipselect !== 1'b0 || bus.sram_write !== 1'b0 ||
            bus.sram_clken !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid v0=%b v1=%b cs=%b we=%b clken=%b want 0 0 0 0 1",
                     bus.m0_readdatavalid, bus.m1_readdatavalid, bus.sram_chipselect,
                     bus.sram_write, bus.sram_clken);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #4;
        checks++;
        if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release v0=%b v1=%b want 0 0",
                     bus.m0_readdatavalid, bus.m1_readdatavalid);
        end
        tick();
    endtask

    task automatic test_write_read();
        set_m(0, 0, 1, 13'h010, 4'hF, 32'h0000_1234);
        #4;
        checks++;
        if (bus.m0_waitrequest !== 1'b0 || bus.sram_chipselect !== 1'b1 ||
            bus.sram_write !== 1'b1 || bus.sram_address !== 13'h010) begin
            errors++;
            $display("FAIL wr_accept wait=%b cs=%b we=%b addr=%h want 0 1 1 010",
                     bus.m0_waitrequest, bus.sram_chipselect, bus.sram_write, bus.sram_address);
        end
        tick();
        set_m(0, 1, 0, 13'h010, 4'h0, 32'h0);
        #4;
        checks++;
        if (bus.sram_write !== 1'b0 || bus.sram_byteenable !== 4'hF ||
            bus.m0_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_accept we=%b be=%h v0=%b want 0 f 0",
                     bus.sram_write, bus.sram_byteenable, bus.m0_readdatavalid);
        end
        tick();
        idle_all();
        #4;
        checks++;
        if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'h0000_1234 ||
            bus.m1_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_return v0=%b d0=%h v1=%b want 1 00001234 0",
                     bus.m0_readdatavalid, bus.m0_readdata, bus.m1_readdatavalid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic prev_w0;
        int   nvalid;
        nvalid = 0;
        prev_w0 = 1'b0;
        set_m(0, 0, 1, 13'h000, 4'hF, 32'hA0A0_0000);
        #4 tick();
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 1, 13'h001, 4'hF, 32'hB1B1_1111);
        #4 tick();
        set_m(0, 1, 0, 13'h000, 4'h0, 32'h0);
        set_m(1, 1, 0, 13'h001, 4'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            #4;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_cycle%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i > 0) begin
                checks++;
                if (bus.m0_waitrequest !== ~prev_w0 || bus.m1_waitrequest !== prev_w0) begin
                    errors++;
                    $display("FAIL b2b_alternate%0d w0=%b w1=%b want %b %b", i,
                             bus.m0_waitrequest, bus.m1_waitrequest, ~prev_w0, prev_w0);
                end
                nvalid += int'(bus.m0_readdatavalid) + int'(bus.m1_readdatavalid);
            end
            prev_w0 = bus.m0_waitrequest;
            tick();
        end
        idle_all();
        #4;
        nvalid += int'(bus.m0_readdatavalid) + int'(bus.m1_readdatavalid);
        checks++;
        if (nvalid !== 8) begin
            errors++;
            $display("FAIL b2b_throughput got %0d returns want 8", nvalid);
        end
        tick();
    endtask

    task automatic test_fixed_priority();
        fbus.m0_read = 1'b1; fbus.m0_address = 13'h002;
        #4 @(posedge clk);
        @(negedge clk);
        // last_grant is now m0; round-robin would have favoured m1.
        fbus.m1_read = 1'b1; fbus.m1_address = 13'h003;
        for (int i = 0; i < 4; i++) begin
            #4;
            checks++;
            if (fbus.m0_waitrequest !== 1'b0 || fbus.m1_waitrequest !== 1'b1 ||
                fbus.sram_address !== 13'h002) begin
                errors++;
                $display("FAIL fixed_prio%0d w0=%b w1=%b addr=%h want 0 1 002", i,
                         fbus.m0_waitrequest, fbus.m1_waitrequest, fbus.sram_address);
            end
            @(posedge clk);
            @(negedge clk);
        end
        fbus.m0_read = 1'b0;
        fbus.m1_read = 1'b0;
    endtask

    task automatic test_freeze();
        set_m(1, 1, 0, 13'h001, 4'h0, 32'h0);
        #4;
        checks++;
        if (bus.m1_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL frz_m1_accept wait=%b want 0", bus.m1_waitrequest);
        end
        tick();
        freeze = 1'b1;
        set_m(1, 0, 0, '0, '0, '0);
        set_m(0, 1, 0, 13'h000, 4'h0, 32'h0);
        #4;
        checks++;
        if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'hB1B1_1111 ||
            bus.sram_chipselect !== 1'b0 || bus.m0_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL frz_drain v1=%b d1=%h cs=%b w0=%b want 1 b1b11111 0 1",
                     bus.m1_readdatavalid, bus.m1_readdata, bus.sram_chipselect,
                     bus.m0_waitrequest);
        end
        tick();
        #4;
        checks++;
        if (bus.sram_chipselect !== 1'b0 || bus.m0_waitrequest !== 1'b1 ||
            bus.m1_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL frz_hold cs=%b w0=%b v1=%b want 0 1 0",
                     bus.sram_chipselect, bus.m0_waitrequest, bus.m1_readdatavalid);
        end
        tick();
        freeze = 1'b0;
        #4;
        checks++;
        if (bus.m0_waitrequest !== 1'b0 || bus.sram_chipselect !== 1'b1 ||
            bus.sram_address !== 13'h000) begin
            errors++;
            $display("FAIL frz_resume w0=%b cs=%b addr=%h want 0 1 000",
                     bus.m0_waitrequest, bus.sram_chipselect, bus.sram_address);
        end
        tick();
        idle_all();
        #4;
        checks++;
        if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'hA0A0_0000) begin
            errors++;
            $display("FAIL frz_m0_return v0=%b d0=%h want 1 a0a00000",
                     bus.m0_readdatavalid, bus.m0_readdata);
        end
        tick();
    endtask

    task automatic test_byteenable();
        set_m(1, 0, 1, 13'h1FFF, 4'hF, 32'hFFFF_FFFF);
        #4 tick();
        set_m(1, 0, 1, 13'h1FFF, 4'b0010, 32'hAABB_CCDD);
        #4;
        checks++;
        if (bus.sram_byteenable !== 4'b0010 || bus.sram_address !== 13'h1FFF) begin
            errors++;
            $display("FAIL be_lanes be=%b addr=%h want 0010 1fff",
                     bus.sram_byteenable, bus.sram_address);
        end
        tick();
        set_m(1, 1, 0, 13'h1FFF, 4'h0, 32'h0);
        #4 tick();
        idle_all();
        #4;
        checks++;
        if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'hFFFF_CCFF) begin
            errors++;
            $display("FAIL be_readback v1=%b d1=%h want 1 ffffccff",
                     bus.m1_readdatavalid, bus.m1_readdata);
        end
        tick();
    endtask

    task automatic test_random();
        bit stall0, stall1;
        int op;
        stall0 = 1'b0;
        stall1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            freeze = ($urandom_range(0, 7) == 0);
            for (int m = 0; m < 2; m++) begin
                if (!((m == 0) ? stall0 : stall1)) begin
                    op = $urandom_range(0, 3);
                    set_m(m, op == 1 || op == 3, op == 2, 13'($urandom_range(0, 15)),
                          4'($urandom), $urandom);
                end
            end
            #4;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand_cycle%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            stall0 = bus.m0_waitrequest;
            stall1 = bus.m1_waitrequest;
            tick();
        end
        freeze = 1'b0;
        idle_all();
        #4;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rand_drain got %h want %h", obs_vec(), exp_vec());
        end
        tick();
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) begin
            sram_mem[a] = 32'h0;
            ref_mem[a]  = 32'h0;
        end
        ref_pref  = 0;
        ref_pend  = 1'b0;
        ref_owner = 0;
        ref_data  = 32'h0;
        idle_all();
        fbus.m0_read = 1'b0; fbus.m0_write = 1'b0; fbus.m0_address = '0;
        fbus.m0_byteenable = '0; fbus.m0_writedata = '0;
        fbus.m1_read = 1'b0; fbus.m1_write = 1'b0; fbus.m1_address = '0;
        fbus.m1_byteenable = '0; fbus.m1_writedata = '0;
        fbus.sram_readdata = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_fixed_priority();
        test_freeze();
        test_byteenable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
